// File: rtl/dmem_read_scheduler.sv
// dmem_read_scheduler
//
// Shares one 64-bit-row data memory among four cores. While idle it
// round-robins a leader among the eligible requests. Every other eligible
// request to the same row joins the batch. It then issues a single row read
// and returns each member's 16-bit word with a one-cycle valid pulse.
//
// Parameters
//   MEM_LATENCY   cycles from the MEMREAD cycle to valid `data` (1..15)
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   MR1..MR4            level load request per core, held until DVALIDi
//   MADDR1..MADDR4      16-bit word address per core
//   data                64-bit row returned by the data memory
//   MEMREAD             one-cycle memory read strobe
//   MEMADDR             row address {2'b0, MADDR[15:2]}
//   DOUT1..DOUT4        registered word per core
//   DVALID1..DVALID4    one-cycle pulse, DOUTi valid
//   STALL1..STALL4      combinational MRi & ~DVALIDi

module dmem_read_scheduler #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MR1,
  input  logic        MR2,
  input  logic        MR3,
  input  logic        MR4,
  input  logic [15:0] MADDR1,
  input  logic [15:0] MADDR2,
  input  logic [15:0] MADDR3,
  input  logic [15:0] MADDR4,
  input  logic [63:0] data,
  output logic        MEMREAD,
  output logic [15:0] MEMADDR,
  output logic [15:0] DOUT1,
  output logic [15:0] DOUT2,
  output logic [15:0] DOUT3,
  output logic [15:0] DOUT4,
  output logic        DVALID1,
  output logic        DVALID2,
  output logic        DVALID3,
  output logic        DVALID4,
  output logic        STALL1,
  output logic        STALL2,
  output logic        STALL3,
  output logic        STALL4
);

  // state      | meaning
  // -----------+--------------------------------------------------------
  // ST_IDLE    | pick leader, form batch from eligible requests
  // ST_ISSUE   | MEMREAD high for this single cycle
  // ST_WAIT    | count 1..MEM_LATENCY, sample data in the last cycle
  // ST_DELIVER | DVALID pulses for surviving batch members

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam logic [3:0] CNT_TC = 4'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grp_q, grp_d;
  logic [13:0] row_q, row_d;
  logic [1:0]  sel_q [4];
  logic [1:0]  sel_d [4];
  logic [3:0]  cnt_q, cnt_d;
  logic        memread_q, memread_d;
  logic [3:0]  dvalid_q, dvalid_d;
  logic [3:0]  done_q, done_d;
  logic [15:0] dout_q [4];
  logic [15:0] dout_d [4];

  logic [3:0]  mr;
  logic [13:0] row_in [4];
  logic [1:0]  sel_in [4];
  logic [3:0]  elig;
  logic        lead_found;
  logic [1:0]  lead_idx;
  logic [1:0]  cand;
  logic [13:0] lead_row;
  logic [3:0]  batch;

  assign mr = {MR4, MR3, MR2, MR1};

  assign row_in[0] = MADDR1[15:2];
  assign row_in[1] = MADDR2[15:2];
  assign row_in[2] = MADDR3[15:2];
  assign row_in[3] = MADDR4[15:2];

  assign sel_in[0] = MADDR1[1:0];
  assign sel_in[1] = MADDR2[1:0];
  assign sel_in[2] = MADDR3[1:0];
  assign sel_in[3] = MADDR4[1:0];

  // A core delivered last cycle may still show its old request while it
  // reacts to DVALID, so it sits out one IDLE evaluation.
  assign elig = mr & ~done_q;

  function automatic logic [15:0] pick_word(input logic [63:0] row,
                                            input logic [1:0]  sel);
    logic [15:0] w;
    case (sel)
      2'd0:    w = row[63:48];
      2'd1:    w = row[47:32];
      2'd2:    w = row[31:16];
      default: w = row[15:0];
    endcase
    return w;
  endfunction

  // Round-robin leader: first eligible core scanning ptr, ptr+1, ... mod 4.
  always_comb begin
    lead_found = 1'b0;
    lead_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!lead_found && elig[cand]) begin
        lead_found = 1'b1;
        lead_idx   = cand;
      end
    end
  end

  assign lead_row = row_in[lead_idx];

  // The leader always matches its own row, so it is part of the batch.
  always_comb begin
    batch = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      batch[i] = elig[i] && (row_in[i] == lead_row);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grp_d     = grp_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    memread_d = 1'b0;
    dvalid_d  = 4'b0000;
    done_d    = dvalid_q;
    for (int i = 0; i < 4; i++) begin
      sel_d[i]  = sel_q[i];
      dout_d[i] = dout_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (lead_found) begin
          state_d   = ST_ISSUE;
          grp_d     = batch;
          row_d     = lead_row;
          ptr_d     = lead_idx + 2'd1;
          memread_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (batch[i]) begin
              sel_d[i] = sel_in[i];
            end
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 4'd1;
      end

      ST_WAIT: begin
        if (cnt_q == CNT_TC) begin
          state_d = ST_DELIVER;
          cnt_d   = 4'd0;
          // Members that dropped MR while the read was in flight get nothing.
          for (int i = 0; i < 4; i++) begin
            if (grp_q[i] && mr[i]) begin
              dvalid_d[i] = 1'b1;
              dout_d[i]   = pick_word(data, sel_q[i]);
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DELIVER: begin
        state_d = ST_IDLE;
        grp_d   = 4'b0000;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 2'd0;
      grp_q     <= 4'b0000;
      row_q     <= 14'd0;
      cnt_q     <= 4'd0;
      memread_q <= 1'b0;
      dvalid_q  <= 4'b0000;
      done_q    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        sel_q[i]  <= 2'd0;
        dout_q[i] <= 16'd0;
      end
    end else begin
      ptr_q     <= ptr_d;
      grp_q     <= grp_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      memread_q <= memread_d;
      dvalid_q  <= dvalid_d;
      done_q    <= done_d;
      for (int i = 0; i < 4; i++) begin
        sel_q[i]  <= sel_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  assign MEMREAD = memread_q;
  assign MEMADDR = {2'b00, row_q};

  assign DOUT1 = dout_q[0];
  assign DOUT2 = dout_q[1];
  assign DOUT3 = dout_q[2];
  assign DOUT4 = dout_q[3];

  assign DVALID1 = dvalid_q[0];
  assign DVALID2 = dvalid_q[1];
  assign DVALID3 = dvalid_q[2];
  assign DVALID4 = dvalid_q[3];

  assign STALL1 = MR1 & ~dvalid_q[0];
  assign STALL2 = MR2 & ~dvalid_q[1];
  assign STALL3 = MR3 & ~dvalid_q[2];
  assign STALL4 = MR4 & ~dvalid_q[3];

endmodule
